// File: rtl/huffman_bit_packer_pkg.sv
// Shared definitions for the Huffman packer: FSM encodings, code-width limits and helpers.
// The decoder uses the same encodings and width rules.
package huffman_bit_packer_pkg;

  localparam logic [1:0] ST_CFG   = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  localparam int MIN_CW = 2;

  // A config write is legal only for widths the decoder can represent.
  function automatic logic cw_legal(input int w, input int max_cw);
    return (w >= MIN_CW) && (w <= max_cw);
  endfunction

endpackage

// File: rtl/huffman_bit_packer_if.sv
// Bundle of the packer's config, symbol and packed-word signals.
// Symbol input: a symbol transfers on a clock edge where en_in && d_req; en_in with d_req=0 is ignored.
// Word output: en_out is a one-cycle valid pulse with no ready; the consumer must always accept.
interface huffman_bit_packer_if #(
  parameter int W   = 8,
  parameter int W_C = 4
);
  logic [W-1:0]   d_conf;
  logic [W-1:0]   h_conf;
  logic [W-1:0]   w_conf;
  logic           en_conf;
  logic           new_conf;
  logic           conf_done;
  logic [W-1:0]   d_in;
  logic           en_in;
  logic           d_req;
  logic           flush;
  logic [W-1:0]   d_out;
  logic           en_out;
  logic [W_C-1:0] pad;
  logic           err;

  modport master (
    output d_conf, h_conf, w_conf, en_conf, new_conf, conf_done, d_in, en_in, flush,
    input  d_req, d_out, en_out, pad, err
  );

  modport slave (
    input  d_conf, h_conf, w_conf, en_conf, new_conf, conf_done, d_in, en_in, flush,
    output d_req, d_out, en_out, pad, err
  );
endinterface

// File: rtl/huffman_bit_packer_code_table.sv
// Symbol-indexed code table: synchronous write, combinational read.
// Only the per-entry valid bits are reset so the width/code storage can map onto RAM.
module huffman_code_table #(
  parameter int W    = 8,
  parameter int CW_W = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            we,
  input  logic [W-1:0]    wr_addr,
  input  logic [CW_W-1:0] wr_width,
  input  logic [W-1:0]    wr_code,
  input  logic [W-1:0]    rd_addr,
  output logic [CW_W-1:0] rd_width,
  output logic [W-1:0]    rd_code
);
  localparam int DEPTH = 2 ** W;

  logic [DEPTH-1:0] valid_q;
  logic [CW_W-1:0]  width_mem [DEPTH];
  logic [W-1:0]     code_mem  [DEPTH];

  // A zero width is a deliberate invalidate of the entry.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      valid_q <= '0;
    end else if (we) begin
      valid_q[wr_addr] <= (wr_width != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      width_mem[wr_addr] <= wr_width;
      code_mem[wr_addr]  <= wr_code;
    end
  end

  assign rd_width = valid_q[rd_addr] ? width_mem[rd_addr] : '0;
  assign rd_code  = valid_q[rd_addr] ? code_mem[rd_addr]  : '0;

endmodule

// File: rtl/huffman_bit_packer.sv
// Huffman packer: maps symbols to table codes and packs them MSB-first into W-bit words,
// one symbol per clock, with an explicit flush that left-aligns and zero-pads the tail.
module huffman_bit_packer
  import huffman_bit_packer_pkg::*;
#(
  parameter int W      = 8,
  parameter int MAX_CW = 8,
  parameter int W_C    = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  huffman_bit_packer_if.slave  bus,
  output logic [1:0]           dbg_state
);
  localparam int AW   = 2 * W;
  localparam int FW   = W_C + 1;
  localparam int CW_W = $clog2(MAX_CW + 1);

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] acc_q, acc_d;
  logic [FW-1:0] fill_q, fill_d;
  logic          err_q, err_d;

  logic [CW_W-1:0] rd_width;
  logic [W-1:0]    rd_code;
  logic [W-1:0]    conf_code;
  logic            conf_ok, conf_inval, tbl_we;
  logic            emit_full, emit_part, accept;
  logic [AW-1:0]   acc_shift, code_ext;
  logic [FW-1:0]   fill_keep, fill_sum, ins_pos, w_ext;

  assign conf_ok    = cw_legal(int'(bus.w_conf), MAX_CW);
  assign conf_inval = (bus.w_conf == '0);
  assign conf_code  = bus.h_conf & ~({W{1'b1}} << bus.w_conf);
  assign tbl_we     = (state_q == ST_CFG) && bus.en_conf && !bus.new_conf && (conf_ok || conf_inval);

  huffman_code_table #(
    .W    (W),
    .CW_W (CW_W)
  ) u_table (
    .clk      (clk),
    .rst      (rst),
    .clr      (bus.new_conf),
    .we       (tbl_we),
    .wr_addr  (bus.d_conf),
    .wr_width (bus.w_conf[CW_W-1:0]),
    .wr_code  (conf_code),
    .rd_addr  (bus.d_in),
    .rd_width (rd_width),
    .rd_code  (rd_code)
  );

  always_comb begin
    emit_full = ((state_q == ST_RUN) || (state_q == ST_FLUSH)) && (fill_q >= FW'(W));
    emit_part = (state_q == ST_FLUSH) && (fill_q != '0) && !emit_full;
    accept    = (state_q == ST_RUN) && bus.en_in;
    acc_shift = emit_full ? (acc_q << W) : acc_q;
    fill_keep = emit_full ? (fill_q - FW'(W)) : fill_q;
    w_ext     = FW'(rd_width);
    fill_sum  = fill_keep + w_ext;
    // New code lands directly below the bits that survive this cycle's emit.
    ins_pos   = FW'(AW) - fill_keep - w_ext;
    code_ext  = {{(AW - W){1'b0}}, rd_code};
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    fill_d  = fill_q;
    err_d   = 1'b0;
    if (bus.new_conf) begin
      state_d = ST_CFG;
      acc_d   = '0;
      fill_d  = '0;
    end else begin
      case (state_q)
        ST_CFG: begin
          if (bus.en_conf && !conf_ok && !conf_inval) err_d = 1'b1;
          if (bus.conf_done) state_d = ST_RUN;
        end
        ST_RUN: begin
          acc_d  = acc_shift;
          fill_d = fill_keep;
          if (accept) begin
            if (rd_width != '0) begin
              acc_d  = acc_shift | (code_ext << ins_pos);
              fill_d = fill_sum;
            end else begin
              err_d = 1'b1;
            end
          end
          if (bus.flush) state_d = ST_FLUSH;
        end
        ST_FLUSH: begin
          if (emit_full) begin
            acc_d  = acc_shift;
            fill_d = fill_keep;
          end else begin
            acc_d   = '0;
            fill_d  = '0;
            state_d = ST_RUN;
          end
        end
        default: state_d = ST_CFG;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_CFG;
      acc_q   <= '0;
      fill_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      fill_q  <= fill_d;
      err_q   <= err_d;
    end
  end

  assign bus.d_req  = (state_q == ST_RUN);
  assign bus.en_out = emit_full || emit_part;
  assign bus.d_out  = acc_q[AW-1 -: W];
  assign bus.pad    = emit_part ? W_C'(FW'(W) - fill_q) : '0;
  assign bus.err    = err_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_huffman_bit_packer.sv
// Bench for huffman_bit_packer: directed scenarios plus a randomized stream checked
// against a bit-queue reference model of the packing rules.
module tb_huffman_bit_packer;
  import huffman_bit_packer_pkg::*;

  localparam int W      = 8;
  localparam int MAX_CW = 8;
  localparam int W_C    = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] dbg_state;

  huffman_bit_packer_if #(.W(W), .W_C(W_C)) bus ();

  huffman_bit_packer #(.W(W), .MAX_CW(MAX_CW), .W_C(W_C)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Scoreboard entries are {pad, word}.
  logic [W_C+W-1:0] exp_q[$];
  logic [W_C+W-1:0] obs_q[$];
  int err_seen = 0;
  int exp_err  = 0;
  int obs_base = 0;
  int err_base = 0;

  int         m_w [256];
  logic [W-1:0] m_c [256];
  bit         m_bits[$];
  bit         m_cfg = 1'b1;

  always @(negedge clk) begin
    if (bus.en_out === 1'b1) obs_q.push_back({bus.pad, bus.d_out});
    if (bus.err === 1'b1) err_seen++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic m_push(input logic [W-1:0] code, input int w);
    logic [W-1:0] word;
    for (int i = w - 1; i >= 0; i--) m_bits.push_back(code[i]);
    while (m_bits.size() >= W) begin
      word = '0;
      for (int i = W - 1; i >= 0; i--) word[i] = m_bits.pop_front();
      exp_q.push_back({W_C'(0), word});
    end
  endtask

  task automatic m_flush();
    logic [W-1:0] word;
    int n;
    n = m_bits.size();
    if (n > 0) begin
      word = '0;
      for (int i = W - 1; i >= W - n; i--) word[i] = m_bits.pop_front();
      exp_q.push_back({W_C'(W - n), word});
    end
  endtask

  task automatic m_clear();
    m_bits.delete();
    for (int i = 0; i < 256; i++) m_w[i] = 0;
  endtask

  task automatic begin_section();
    exp_q.delete();
    obs_base = obs_q.size();
    err_base = err_seen;
    exp_err  = 0;
  endtask

  task automatic cfg(input logic [W-1:0] sym, input logic [W-1:0] code, input int w);
    bus.d_conf  = sym;
    bus.h_conf  = code;
    bus.w_conf  = W'(w);
    bus.en_conf = 1'b1;
    tick();
    bus.en_conf = 1'b0;
    if (m_cfg) begin
      if (w == 0) m_w[sym] = 0;
      else if (w >= MIN_CW && w <= MAX_CW) begin
        m_w[sym] = w;
        m_c[sym] = W'(int'(code) & ((1 << w) - 1));
      end else exp_err++;
    end
  endtask

  task automatic run();
    bus.conf_done = 1'b1;
    tick();
    bus.conf_done = 1'b0;
    m_cfg = 1'b0;
  endtask

  task automatic new_conf_pulse();
    bus.new_conf = 1'b1;
    tick();
    bus.new_conf = 1'b0;
    m_clear();
    m_cfg = 1'b1;
  endtask

  task automatic send(input logic [W-1:0] sym, input bit fl);
    bus.d_in  = sym;
    bus.en_in = 1'b1;
    bus.flush = fl;
    tick();
    bus.en_in = 1'b0;
    bus.flush = 1'b0;
    if (m_w[sym] != 0) m_push(m_c[sym], m_w[sym]);
    else exp_err++;
    if (fl) m_flush();
  endtask

  task automatic wait_run();
    for (int k = 0; k < 8; k++) if (dbg_state !== ST_RUN) tick();
  endtask

  task automatic do_flush();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    m_flush();
    wait_run();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle(2);
    n_tests++; if (bus.d_req !== 1'b0) begin n_fail++; $display("FAIL reset_d_req: got %b want 0", bus.d_req); end
    n_tests++; if (bus.en_out !== 1'b0) begin n_fail++; $display("FAIL reset_en_out: got %b want 0", bus.en_out); end
    n_tests++; if (bus.d_out !== 8'h00) begin n_fail++; $display("FAIL reset_d_out: got %h want 00", bus.d_out); end
    n_tests++; if (bus.pad !== 4'h0) begin n_fail++; $display("FAIL reset_pad: got %0d want 0", bus.pad); end
    n_tests++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", bus.err); end
    n_tests++; if (dbg_state !== ST_CFG) begin n_fail++; $display("FAIL reset_state: got %0d want %0d", dbg_state, ST_CFG); end
    rst = 1'b0;
    m_clear();
    m_cfg = 1'b1;
  endtask

  task automatic test_spec_example();
    logic [W_C+W-1:0] w0, w1;
    w0 = 12'h0B3;
    w1 = 12'h780;
    begin_section();
    new_conf_pulse();
    cfg(8'h41, 8'h02, 2);
    cfg(8'h42, 8'h06, 3);
    cfg(8'h43, 8'h07, 4);
    bus.d_in = 8'h41; bus.en_in = 1'b1;
    tick();
    bus.en_in = 1'b0;
    run();
    cfg(8'h41, 8'h03, 2);
    send(8'h41, 1'b0);
    send(8'h42, 1'b0);
    send(8'h43, 1'b0);
    idle(2);
    do_flush();
    idle(3);
    n_tests++; if (dbg_state !== ST_RUN) begin n_fail++; $display("FAIL spec_state: got %0d want %0d", dbg_state, ST_RUN); end
    n_tests++;
    if (obs_q.size() - obs_base != exp_q.size()) begin n_fail++; $display("FAIL spec_words: got %0d want %0d", obs_q.size() - obs_base, exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) if (obs_base + i < obs_q.size()) begin
      n_tests++; if (obs_q[obs_base + i] !== exp_q[i]) begin n_fail++; $display("FAIL spec_word%0d: got %h want %h", i, obs_q[obs_base + i], exp_q[i]); end
    end
    n_tests++;
    if (obs_q.size() < obs_base + 2 || obs_q[obs_base] !== w0 || obs_q[obs_base + 1] !== w1) begin
      n_fail++; $display("FAIL spec_const: got %0d words first %h want %h then %h", obs_q.size() - obs_base, obs_q[obs_base], w0, w1);
    end
    n_tests++; if (err_seen - err_base != exp_err) begin n_fail++; $display("FAIL spec_err: got %0d want %0d", err_seen - err_base, exp_err); end
  endtask

  task automatic test_back_to_back();
    logic [W_C+W-1:0] aa;
    aa = 12'h0AA;
    begin_section();
    bus.d_in  = 8'h41;
    bus.en_in = 1'b1;
    for (int i = 0; i < 8; i++) begin
      n_tests++; if (bus.d_req !== 1'b1) begin n_fail++; $display("FAIL b2b_d_req%0d: got %b want 1", i, bus.d_req); end
      tick();
      m_push(m_c[8'h41], m_w[8'h41]);
    end
    bus.en_in = 1'b0;
    idle(3);
    n_tests++;
    if (obs_q.size() - obs_base != exp_q.size()) begin n_fail++; $display("FAIL b2b_words: got %0d want %0d", obs_q.size() - obs_base, exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) if (obs_base + i < obs_q.size()) begin
      n_tests++; if (obs_q[obs_base + i] !== exp_q[i]) begin n_fail++; $display("FAIL b2b_word%0d: got %h want %h", i, obs_q[obs_base + i], exp_q[i]); end
    end
    n_tests++;
    if (obs_q.size() != obs_base + 2 || obs_q[obs_base] !== aa || obs_q[obs_base + 1] !== aa) begin
      n_fail++; $display("FAIL b2b_const: got %0d words first %h want 2 words of %h", obs_q.size() - obs_base, obs_q[obs_base], aa);
    end
  endtask

  task automatic test_invalid_symbol();
    begin_section();
    send(8'h41, 1'b0);
    send(8'h55, 1'b0);
    send(8'h42, 1'b0);
    send(8'h43, 1'b0);
    send(8'h41, 1'b0);
    idle(2);
    do_flush();
    idle(3);
    n_tests++;
    if (obs_q.size() - obs_base != exp_q.size()) begin n_fail++; $display("FAIL inval_words: got %0d want %0d", obs_q.size() - obs_base, exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) if (obs_base + i < obs_q.size()) begin
      n_tests++; if (obs_q[obs_base + i] !== exp_q[i]) begin n_fail++; $display("FAIL inval_word%0d: got %h want %h", i, obs_q[obs_base + i], exp_q[i]); end
    end
    n_tests++; if (err_seen - err_base != exp_err) begin n_fail++; $display("FAIL inval_err: got %0d want %0d", err_seen - err_base, exp_err); end
  endtask

  task automatic test_bad_config();
    begin_section();
    new_conf_pulse();
    cfg(8'h41, 8'h02, 2);
    cfg(8'h41, 8'hFF, 9);
    cfg(8'h42, 8'h06, 3);
    cfg(8'h42, 8'h00, 0);
    cfg(8'h43, 8'hF7, 4);
    cfg(8'h44, 8'h01, 1);
    run();
    send(8'h41, 1'b0);
    send(8'h42, 1'b0);
    send(8'h43, 1'b0);
    send(8'h44, 1'b0);
    idle(2);
    do_flush();
    idle(3);
    n_tests++;
    if (obs_q.size() - obs_base != exp_q.size()) begin n_fail++; $display("FAIL badcfg_words: got %0d want %0d", obs_q.size() - obs_base, exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) if (obs_base + i < obs_q.size()) begin
      n_tests++; if (obs_q[obs_base + i] !== exp_q[i]) begin n_fail++; $display("FAIL badcfg_word%0d: got %h want %h", i, obs_q[obs_base + i], exp_q[i]); end
    end
    n_tests++; if (err_seen - err_base != exp_err) begin n_fail++; $display("FAIL badcfg_err: got %0d want %0d", err_seen - err_base, exp_err); end
  endtask

  task automatic test_new_conf_mid();
    new_conf_pulse();
    cfg(8'h41, 8'h02, 2);
    cfg(8'h42, 8'h06, 3);
    run();
    begin_section();
    send(8'h41, 1'b0);
    send(8'h42, 1'b0);
    bus.new_conf = 1'b1;
    bus.en_conf  = 1'b1;
    bus.d_conf   = 8'h43; bus.h_conf = 8'h07; bus.w_conf = 8'd4;
    tick();
    bus.new_conf = 1'b0;
    bus.en_conf  = 1'b0;
    m_clear();
    m_cfg = 1'b1;
    idle(2);
    n_tests++; if (obs_q.size() != obs_base) begin n_fail++; $display("FAIL newconf_no_out: got %0d words want 0", obs_q.size() - obs_base); end
    n_tests++; if (dbg_state !== ST_CFG) begin n_fail++; $display("FAIL newconf_state: got %0d want %0d", dbg_state, ST_CFG); end
    cfg(8'h42, 8'h06, 3);
    run();
    send(8'h41, 1'b0);
    send(8'h42, 1'b0);
    send(8'h43, 1'b0);
    idle(2);
    do_flush();
    idle(3);
    n_tests++;
    if (obs_q.size() - obs_base != exp_q.size()) begin n_fail++; $display("FAIL newconf_words: got %0d want %0d", obs_q.size() - obs_base, exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) if (obs_base + i < obs_q.size()) begin
      n_tests++; if (obs_q[obs_base + i] !== exp_q[i]) begin n_fail++; $display("FAIL newconf_word%0d: got %h want %h", i, obs_q[obs_base + i], exp_q[i]); end
    end
    n_tests++; if (err_seen - err_base != exp_err) begin n_fail++; $display("FAIL newconf_err: got %0d want %0d", err_seen - err_base, exp_err); end
  endtask

  task automatic test_flush_empty();
    begin_section();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    n_tests++; if (dbg_state !== ST_FLUSH) begin n_fail++; $display("FAIL fempty_state1: got %0d want %0d", dbg_state, ST_FLUSH); end
    n_tests++; if (bus.en_out !== 1'b0) begin n_fail++; $display("FAIL fempty_en_out: got %b want 0", bus.en_out); end
    tick();
    n_tests++; if (dbg_state !== ST_RUN) begin n_fail++; $display("FAIL fempty_state2: got %0d want %0d", dbg_state, ST_RUN); end
    idle(2);
    n_tests++; if (obs_q.size() != obs_base) begin n_fail++; $display("FAIL fempty_words: got %0d want 0", obs_q.size() - obs_base); end
  endtask

  task automatic test_rst_mid_flush();
    new_conf_pulse();
    cfg(8'h43, 8'h07, 4);
    run();
    send(8'h43, 1'b0);
    send(8'h43, 1'b0);
    send(8'h43, 1'b0);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    n_tests++; if (dbg_state !== ST_FLUSH) begin n_fail++; $display("FAIL rstfl_in_flush: got %0d want %0d", dbg_state, ST_FLUSH); end
    rst = 1'b1;
    tick();
    n_tests++; if (bus.en_out !== 1'b0) begin n_fail++; $display("FAIL rstfl_en_out: got %b want 0", bus.en_out); end
    n_tests++; if (bus.d_out !== 8'h00) begin n_fail++; $display("FAIL rstfl_d_out: got %h want 00", bus.d_out); end
    n_tests++; if (bus.pad !== 4'h0) begin n_fail++; $display("FAIL rstfl_pad: got %0d want 0", bus.pad); end
    n_tests++; if (bus.d_req !== 1'b0) begin n_fail++; $display("FAIL rstfl_d_req: got %b want 0", bus.d_req); end
    n_tests++; if (dbg_state !== ST_CFG) begin n_fail++; $display("FAIL rstfl_state: got %0d want %0d", dbg_state, ST_CFG); end
    rst = 1'b0;
    m_clear();
    m_cfg = 1'b1;
    idle(1);
  endtask

  task automatic test_random();
    logic [W-1:0] sym;
    bit fl;
    int w;
    begin_section();
    new_conf_pulse();
    for (int i = 0; i < 16; i++) begin
      w = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 10)) : int'($urandom_range(2, 8));
      cfg(8'(32'h60 + i), 8'($urandom_range(0, 255)), w);
    end
    run();
    for (int i = 0; i < 60; i++) begin
      sym = 8'(32'h60 + $urandom_range(0, 19));
      fl  = ($urandom_range(0, 7) == 0);
      send(sym, fl);
      if (fl) begin
        wait_run();
        n_tests++; if (dbg_state !== ST_RUN) begin n_fail++; $display("FAIL rand_flush_timeout%0d: got %0d want %0d", i, dbg_state, ST_RUN); end
      end else begin
        idle($urandom_range(0, 2));
      end
    end
    idle(2);
    do_flush();
    idle(3);
    n_tests++;
    if (obs_q.size() - obs_base != exp_q.size()) begin n_fail++; $display("FAIL rand_words: got %0d want %0d", obs_q.size() - obs_base, exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) if (obs_base + i < obs_q.size()) begin
      n_tests++; if (obs_q[obs_base + i] !== exp_q[i]) begin n_fail++; $display("FAIL rand_word%0d: got %h want %h", i, obs_q[obs_base + i], exp_q[i]); end
    end
    n_tests++; if (err_seen - err_base != exp_err) begin n_fail++; $display("FAIL rand_err: got %0d want %0d", err_seen - err_base, exp_err); end
  endtask

  initial begin
    bus.d_conf = '0; bus.h_conf = '0; bus.w_conf = '0;
    bus.en_conf = 1'b0; bus.new_conf = 1'b0; bus.conf_done = 1'b0;
    bus.d_in = '0; bus.en_in = 1'b0; bus.flush = 1'b0;
    m_clear();
    test_reset();
    test_spec_example();
    test_back_to_back();
    test_invalid_symbol();
    test_bad_config();
    test_new_conf_mid();
    test_flush_empty();
    test_rst_mid_flush();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
